// File: rtl/ycr_route_pkg.sv
// Shared definitions for the requester-to-memory router: response codes and FSM states.
package ycr_route_pkg;

    localparam logic [1:0] RESP_IDLE = 2'b00;
    localparam logic [1:0] RESP_RDY  = 2'b01;
    localparam logic [1:0] RESP_ERR  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_RESP = 2'd1,
        ST_RESP_OUT  = 2'd2
    } route_state_e;

    // Any non-IDLE code from the slave counts as a response (including the unused 2'b11).
    function automatic logic resp_valid(input logic [1:0] resp);
        return resp != RESP_IDLE;
    endfunction

endpackage

// File: rtl/ycr_route_tmo.sv
// Response timeout counter for ycr_req_route; only instantiated when YCR_ROUTE_TIMEOUT_EN is defined.
module ycr_route_tmo #(
    parameter int unsigned TMO_CYC = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic run,
    output logic expire
);

    localparam int CW = $clog2(TMO_CYC) + 1;
    // Cleared at acceptance, so the count reaches TMO_CYC-1 on the edge that leaves WAIT_RESP.
    localparam logic [CW-1:0] LIM = CW'(TMO_CYC - 2);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expire = run && (cnt == LIM);

endmodule

// File: rtl/ycr_req_route.sv
// Routes the arbiter-granted requester's command to a single memory port and returns the
// response to the original requester. Optional response timeout: define YCR_ROUTE_TIMEOUT_EN.
module ycr_req_route
    import ycr_route_pkg::*;
#(
    parameter int unsigned TREQ    = 2,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TMO_CYC = 256,
    localparam int TREQ_DW = $clog2(TREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [TREQ_DW:0]     gnt,
    input  logic [TREQ-1:0]      m_req,
    input  logic [TREQ-1:0]      m_cmd,
    input  logic [TREQ*AW-1:0]   m_addr,
    input  logic [TREQ*DW-1:0]   m_wdata,
    input  logic [TREQ*2-1:0]    m_width,
    output logic [TREQ-1:0]      m_req_ack,
    output logic [TREQ*2-1:0]    m_resp,
    output logic [TREQ*DW-1:0]   m_rdata,
    output logic                 s_req,
    output logic                 s_cmd,
    output logic [AW-1:0]        s_addr,
    output logic [DW-1:0]        s_wdata,
    output logic [1:0]           s_width,
    input  logic                 s_req_ack,
    input  logic [1:0]           s_resp,
    input  logic [DW-1:0]        s_rdata,
    output logic                 req_ack,
    output logic                 lack
);

    if (TMO_CYC < 2) begin : g_bad_tmo
        $error("ycr_req_route: TMO_CYC must be at least 2");
    end

    route_state_e state, state_next;

    logic [TREQ_DW:0] id_q;
    logic [1:0]       resp_q;
    logic [DW-1:0]    rdata_q;
    logic             tmo_expire;
    logic             gnt_req;

    // Grant decode: an out-of-range grant (including all-ones) selects nobody.
    always_comb begin
        gnt_req = 1'b0;
        s_cmd   = 1'b0;
        s_addr  = '0;
        s_wdata = '0;
        s_width = '0;
        for (int i = 0; i < int'(TREQ); i++) begin
            if (gnt == i[TREQ_DW:0]) begin
                gnt_req = m_req[i];
                s_cmd   = m_cmd[i];
                s_addr  = m_addr[i*AW +: AW];
                s_wdata = m_wdata[i*DW +: DW];
                s_width = m_width[i*2 +: 2];
            end
        end
    end

    always_comb begin
        s_req     = (state == ST_IDLE) && !rst && gnt_req;
        req_ack   = s_req && s_req_ack;
        lack      = (state == ST_RESP_OUT) && !rst;
        m_req_ack = '0;
        m_resp    = '0;
        m_rdata   = '0;
        for (int i = 0; i < int'(TREQ); i++) begin
            if (gnt == i[TREQ_DW:0]) begin
                m_req_ack[i] = req_ack;
            end
            if (lack && (id_q == i[TREQ_DW:0])) begin
                m_resp[i*2 +: 2]   = resp_q;
                m_rdata[i*DW +: DW] = rdata_q;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (req_ack) begin
                    state_next = ST_WAIT_RESP;
                end
            end
            ST_WAIT_RESP: begin
                if (resp_valid(s_resp) || tmo_expire) begin
                    state_next = ST_RESP_OUT;
                end
            end
            ST_RESP_OUT: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A genuine slave response in the same cycle as the timeout wins over ERR.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_q    <= '0;
            resp_q  <= RESP_IDLE;
            rdata_q <= '0;
        end else begin
            if (req_ack) begin
                id_q <= gnt;
            end
            if (state == ST_WAIT_RESP) begin
                if (resp_valid(s_resp)) begin
                    resp_q  <= s_resp;
                    rdata_q <= s_rdata;
                end else if (tmo_expire) begin
                    resp_q  <= RESP_ERR;
                    rdata_q <= '0;
                end
            end
        end
    end

`ifdef YCR_ROUTE_TIMEOUT_EN
    ycr_route_tmo #(
        .TMO_CYC (TMO_CYC)
    ) u_tmo (
        .clk    (clk),
        .rst    (rst),
        .start  (req_ack),
        .run    (state == ST_WAIT_RESP),
        .expire (tmo_expire)
    );
`else
    assign tmo_expire = 1'b0;
`endif

endmodule

// File: tb/tb_ycr_req_route.sv
// Self-checking bench for ycr_req_route: vector table, directed sequences and a randomized
// transaction run against a transaction-level expectation.
module tb_ycr_req_route;

    localparam logic [1:0] R_IDLE = 2'b00;
    localparam logic [1:0] R_RDY  = 2'b01;
    localparam logic [1:0] R_ERR  = 2'b10;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  gnt;
    logic [1:0]  m_req, m_cmd;
    logic [63:0] m_addr, m_wdata;
    logic [3:0]  m_width;
    logic [1:0]  m_req_ack;
    logic [3:0]  m_resp;
    logic [63:0] m_rdata;
    logic        s_req, s_cmd;
    logic [31:0] s_addr, s_wdata;
    logic [1:0]  s_width;
    logic        s_req_ack;
    logic [1:0]  s_resp;
    logic [31:0] s_rdata;
    logic        req_ack, lack;

    int checks = 0;
    int failures = 0;

    ycr_req_route #(.TREQ(2), .AW(32), .DW(32), .TMO_CYC(8)) dut (
        .clk(clk), .rst(rst), .gnt(gnt), .m_req(m_req), .m_cmd(m_cmd),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_width(m_width),
        .m_req_ack(m_req_ack), .m_resp(m_resp), .m_rdata(m_rdata),
        .s_req(s_req), .s_cmd(s_cmd), .s_addr(s_addr), .s_wdata(s_wdata), .s_width(s_width),
        .s_req_ack(s_req_ack), .s_resp(s_resp), .s_rdata(s_rdata),
        .req_ack(req_ack), .lack(lack)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // Expected response vectors for a given owner, built from plain shifts.
    function automatic logic [3:0] exp_resp(input int owner, input logic [1:0] r);
        return 4'(r) << (2 * owner);
    endfunction

    function automatic logic [63:0] exp_rdata(input int owner, input logic [31:0] d);
        return 64'(d) << (32 * owner);
    endfunction

    task automatic idle_inputs();
        m_req = 2'b00; s_req_ack = 1'b0; s_resp = R_IDLE; s_rdata = '0; gnt = 2'b11;
    endtask

    // Complete a transaction already accepted for owner with an RDY response.
    task automatic finish_txn(input int owner, input string tag);
        logic [31:0] d;
        d = $urandom;
        idle_inputs();
        s_resp = R_RDY; s_rdata = d;
        step();
        s_resp = R_IDLE;
        settle();
        chk({tag, "_lack"}, 64'(lack), 64'd1);
        chk({tag, "_mresp"}, 64'(m_resp), 64'(exp_resp(owner, R_RDY)));
        chk({tag, "_mrdata"}, m_rdata, exp_rdata(owner, d));
        step();
    endtask

    typedef struct {
        logic [1:0] gnt;
        logic [1:0] mreq;
        logic [1:0] mcmd;
        logic       sack;
        logic       e_sreq;
        logic       e_scmd;
        logic [1:0] e_mack;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [1:0]  r;
        logic [31:0] d;
        logic [31:0] a0, a1, w0, w1;
        logic [1:0]  wd0, wd1;
        int          g, owner, dly;
        logic        exp_s, exp_acc;

        vecs[0] = '{2'd0, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00};
        vecs[1] = '{2'd1, 2'b10, 2'b10, 1'b1, 1'b1, 1'b1, 2'b10};
        vecs[2] = '{2'd3, 2'b11, 2'b11, 1'b1, 1'b0, 1'b0, 2'b00};
        vecs[3] = '{2'd2, 2'b11, 2'b11, 1'b1, 1'b0, 1'b0, 2'b00};
        vecs[4] = '{2'd0, 2'b10, 2'b11, 1'b1, 1'b0, 1'b0, 2'b00};
        vecs[5] = '{2'd0, 2'b01, 2'b01, 1'b1, 1'b1, 1'b1, 2'b01};
        vecs[6] = '{2'd1, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00};

        m_addr = {32'h0000_0100, 32'h0000_0200};
        m_wdata = {32'h1111_1111, 32'h2222_2222};
        m_width = 4'b10_01;
        m_cmd = 2'b00;

        // Reset with every input trying to provoke activity.
        rst = 1'b1; gnt = 2'd0; m_req = 2'b11; s_req_ack = 1'b1; s_resp = R_RDY; s_rdata = 32'hFFFF_FFFF;
        step(); step();
        settle();
        chk("rst_sreq", 64'(s_req), 64'd0);
        chk("rst_reqack", 64'(req_ack), 64'd0);
        chk("rst_mreqack", 64'(m_req_ack), 64'd0);
        chk("rst_lack", 64'(lack), 64'd0);
        chk("rst_mresp", 64'(m_resp), 64'd0);
        chk("rst_mrdata", m_rdata, 64'd0);
        rst = 1'b0;
        idle_inputs();
        step();
        settle();
        chk("post_rst_lack", 64'(lack), 64'd0);
        chk("post_rst_mresp", 64'(m_resp), 64'd0);

        // Vector table of IDLE-state routing.
        for (int i = 0; i < 7; i++) begin
            gnt = vecs[i].gnt; m_req = vecs[i].mreq; m_cmd = vecs[i].mcmd; s_req_ack = vecs[i].sack;
            settle();
            chk($sformatf("vec%0d_sreq", i), 64'(s_req), 64'(vecs[i].e_sreq));
            chk($sformatf("vec%0d_reqack", i), 64'(req_ack), 64'(vecs[i].e_sreq & vecs[i].sack));
            chk($sformatf("vec%0d_mack", i), 64'(m_req_ack), 64'(vecs[i].e_mack));
            if (vecs[i].e_sreq) begin
                chk($sformatf("vec%0d_scmd", i), 64'(s_cmd), 64'(vecs[i].e_scmd));
                chk($sformatf("vec%0d_saddr", i), 64'(s_addr),
                    (vecs[i].gnt == 2'd1) ? 64'h100 : 64'h200);
                chk($sformatf("vec%0d_swidth", i), 64'(s_width),
                    (vecs[i].gnt == 2'd1) ? 64'd2 : 64'd1);
            end
            step();
            if (vecs[i].e_sreq && vecs[i].sack) begin
                idle_inputs();
                settle();
                chk($sformatf("vec%0d_ack_pulse", i), 64'(req_ack), 64'd0);
                chk($sformatf("vec%0d_mack_pulse", i), 64'(m_req_ack), 64'd0);
                finish_txn(int'(vecs[i].gnt), $sformatf("vec%0d_drain", i));
            end
        end

        // Read for id 0, response three cycles after acceptance.
        idle_inputs();
        gnt = 2'd0; m_req = 2'b01; m_cmd = 2'b00; s_req_ack = 1'b1;
        settle();
        chk("rd0_reqack", 64'(req_ack), 64'd1);
        step();
        idle_inputs();
        step(); step();
        s_resp = R_RDY; s_rdata = 32'hDEAD_BEEF;
        step();
        s_resp = R_IDLE; s_rdata = '0;
        settle();
        chk("rd0_lack", 64'(lack), 64'd1);
        chk("rd0_mresp", 64'(m_resp), 64'(4'b0001));
        chk("rd0_mrdata", m_rdata, 64'h0000_0000_DEAD_BEEF);
        step();
        settle();
        chk("rd0_lack_drop", 64'(lack), 64'd0);
        chk("rd0_mresp_drop", 64'(m_resp), 64'd0);

        // Accept id 1, grant moves to 0 while waiting, ERR must go to requester 1.
        gnt = 2'd1; m_req = 2'b10; s_req_ack = 1'b1;
        step();
        gnt = 2'd0; m_req = 2'b01;
        settle();
        chk("gsw_sreq_wait", 64'(s_req), 64'd0);
        s_resp = R_ERR; s_rdata = 32'h1234_5678;
        step();
        s_resp = R_IDLE;
        m_req = 2'b00;
        settle();
        chk("gsw_mresp", 64'(m_resp), 64'(4'b1000));
        chk("gsw_mrdata", m_rdata, 64'h1234_5678_0000_0000);
        step();

        // Request withdrawn before any slave ack, then a normal request on id 1.
        idle_inputs();
        gnt = 2'd0; m_req = 2'b01; s_req_ack = 1'b0;
        settle();
        chk("drop_reqack_a", 64'(req_ack), 64'd0);
        step();
        settle();
        chk("drop_sreq_b", 64'(s_req), 64'd1);
        step();
        m_req = 2'b00; s_req_ack = 1'b1;
        settle();
        chk("drop_sreq_gone", 64'(s_req), 64'd0);
        step();
        gnt = 2'd1; m_req = 2'b10;
        settle();
        chk("drop_then_acc", 64'(m_req_ack), 64'(2'b10));
        step();
        finish_txn(1, "drop_drain");

        // Reset while waiting; the late slave response must be dropped.
        idle_inputs();
        gnt = 2'd0; m_req = 2'b01; s_req_ack = 1'b1;
        step();
        idle_inputs();
        rst = 1'b1;
        settle();
        chk("rstw_lack", 64'(lack), 64'd0);
        step();
        rst = 1'b0;
        s_resp = R_RDY; s_rdata = 32'hCAFE_F00D;
        step();
        s_resp = R_IDLE;
        settle();
        chk("rstw_no_lack", 64'(lack), 64'd0);
        chk("rstw_mresp", 64'(m_resp), 64'd0);
        gnt = 2'd1; m_req = 2'b10; s_req_ack = 1'b1;
        settle();
        chk("rstw_accept", 64'(req_ack), 64'd1);
        step();
        finish_txn(1, "rstw_drain");

`ifdef YCR_ROUTE_TIMEOUT_EN
        // No slave response: ERR with zero data eight cycles after acceptance.
        idle_inputs();
        gnt = 2'd1; m_req = 2'b10; s_req_ack = 1'b1;
        step();
        idle_inputs();
        for (int k = 1; k < 8; k++) begin
            settle();
            chk($sformatf("tmo_wait%0d_lack", k), 64'(lack), 64'd0);
            step();
        end
        settle();
        chk("tmo_lack", 64'(lack), 64'd1);
        chk("tmo_mresp", 64'(m_resp), 64'(4'b1000));
        chk("tmo_mrdata", m_rdata, 64'd0);
        step();
        s_resp = R_RDY; s_rdata = 32'h5555_AAAA;
        step();
        s_resp = R_IDLE;
        settle();
        chk("tmo_late_lack", 64'(lack), 64'd0);
        chk("tmo_late_mresp", 64'(m_resp), 64'd0);
`endif

        // Randomized transactions checked against the routing rules.
        for (int n = 0; n < 300; n++) begin
            g = int'($urandom_range(0, 3));
            gnt = 2'(g);
            m_req = 2'($urandom); m_cmd = 2'($urandom);
            a0 = $urandom; a1 = $urandom; w0 = $urandom; w1 = $urandom;
            wd0 = 2'($urandom); wd1 = 2'($urandom);
            m_addr = {a1, a0}; m_wdata = {w1, w0}; m_width = {wd1, wd0};
            s_req_ack = 1'($urandom);
            s_resp = R_IDLE;
            settle();
            exp_s = (g < 2) && m_req[g];
            exp_acc = exp_s && s_req_ack;
            chk("rnd_sreq", 64'(s_req), 64'(exp_s));
            chk("rnd_reqack", 64'(req_ack), 64'(exp_acc));
            chk("rnd_mack", 64'(m_req_ack), exp_acc ? (64'd1 << g) : 64'd0);
            chk("rnd_idle_mresp", 64'(m_resp), 64'd0);
            if (exp_s) begin
                chk("rnd_saddr", 64'(s_addr), 64'((g == 1) ? a1 : a0));
                chk("rnd_swdata", 64'(s_wdata), 64'((g == 1) ? w1 : w0));
                chk("rnd_scmd", 64'(s_cmd), 64'(m_cmd[g]));
                chk("rnd_swidth", 64'(s_width), 64'((g == 1) ? wd1 : wd0));
            end
            step();
            if (exp_acc) begin
                owner = g;
                dly = int'($urandom_range(0, 4));
                for (int k = 0; k < dly; k++) begin
                    gnt = 2'($urandom); m_req = 2'($urandom); s_req_ack = 1'($urandom);
                    s_resp = R_IDLE;
                    settle();
                    chk("rnd_wait_sreq", 64'(s_req), 64'd0);
                    chk("rnd_wait_lack", 64'(lack), 64'd0);
                    step();
                end
                r = $urandom_range(0, 1) ? R_RDY : R_ERR;
                d = $urandom;
                s_resp = r; s_rdata = d;
                gnt = 2'($urandom); m_req = 2'($urandom);
                step();
                gnt = 2'($urandom_range(0, 1)); m_req = 2'b11; s_req_ack = 1'b1;
                s_resp = R_RDY; s_rdata = $urandom;
                settle();
                chk("rnd_lack", 64'(lack), 64'd1);
                chk("rnd_mresp", 64'(m_resp), 64'(exp_resp(owner, r)));
                chk("rnd_mrdata", m_rdata, exp_rdata(owner, d));
                chk("rnd_no_early_acc", 64'(req_ack), 64'd0);
                step();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ycr_req_route.md
YCR_REQ_ROUTE -- requirements
Module: ycr_req_route

Interface
REQ-001 SHALL have parameter TREQ, default 2, number of requesters.
REQ-002 SHALL have parameter AW, default 32, address width; DW, default 32, data width; TMO_CYC, default 256, response timeout cycles.
REQ-003 SHALL derive TREQ_DW = $clog2(TREQ).
REQ-004 SHALL have clk, input, 1: single clock, all logic on rising edge.
REQ-005 SHALL have rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have gnt, input, TREQ_DW+1: granted requester index from arbiter; all-ones = no grant.
REQ-007 SHALL have m_req/m_cmd, input, TREQ each: per-requester request and write flag (1 = write).
REQ-008 SHALL have m_addr/m_wdata/m_width, input, TREQ*AW / TREQ*DW / TREQ*2: packed per-requester command fields.
REQ-009 SHALL have m_req_ack, output, TREQ; m_resp, output, TREQ*2; m_rdata, output, TREQ*DW.
REQ-010 SHALL have s_req, s_cmd, s_addr, s_wdata, s_width as outputs of width 1, 1, AW, DW, 2 to the memory side.
REQ-011 SHALL have s_req_ack, input, 1; s_resp, input, 2; s_rdata, input, DW.
REQ-012 SHALL have req_ack, output, 1, and lack, output, 1, both to the arbiter.

Function
REQ-013 SHALL encode resp as 2'b00 IDLE, 2'b01 RDY, 2'b10 ERR.
REQ-014 SHALL use FSM states IDLE, WAIT_RESP, RESP_OUT.
REQ-015 IDLE, gnt < TREQ: s_req = m_req[gnt] and s_cmd/s_addr/s_wdata/s_width = slice gnt, combinational. Any other state or gnt >= TREQ: s_req = 0.
REQ-016 IDLE: s_req & s_req_ack SHALL assert req_ack and m_req_ack[gnt] for that cycle, latch gnt into id_q, and go to WAIT_RESP next cycle.
REQ-017 If m_req[gnt] drops before s_req_ack, SHALL latch nothing and stay in IDLE.
REQ-018 WAIT_RESP: s_resp != IDLE SHALL register s_resp/s_rdata and go to RESP_OUT. Only one transaction outstanding.
REQ-019 RESP_OUT, for exactly one cycle: SHALL drive m_resp[id_q] and m_rdata[id_q] from the registers and assert lack, then return to IDLE. Latency from s_resp to m_resp is 1 cycle.
REQ-020 m_resp of non-selected requesters SHALL be IDLE and their m_rdata 0 at all times.
REQ-021 Routing of the response SHALL use id_q only; gnt changes after acceptance SHALL NOT affect it.
REQ-022 s_resp != IDLE while in IDLE or RESP_OUT SHALL be ignored.
REQ-023 A new command SHALL be accepted no earlier than the cycle after RESP_OUT.

Reset
REQ-024 rst SHALL force state IDLE, id_q 0, response registers 0, and the timeout counter 0.
REQ-025 During reset, all m_req_ack, m_resp, m_rdata, s_req, req_ack and lack SHALL be 0. Reset mid-transaction SHALL discard the pending response without asserting lack.

Configuration
REQ-026 With YCR_ROUTE_TIMEOUT_EN defined:
- a counter SHALL clear on entry to WAIT_RESP and increment each WAIT_RESP cycle.
- On reaching TMO_CYC-1 without s_resp, it SHALL go to RESP_OUT with resp ERR and rdata 0.
- A later slave response SHALL be ignored per REQ-022.
REQ-027 Without YCR_ROUTE_TIMEOUT_EN, no counter logic SHALL exist and WAIT_RESP SHALL wait indefinitely.

Structure
REQ-028 Resp encoding constants and the FSM state enum SHALL live in shared package ycr_route_pkg.
REQ-029 The timeout counter SHALL be sub-module ycr_route_tmo, instantiated only under YCR_ROUTE_TIMEOUT_EN.

Verification
REQ-030 gnt=1, m_req=2'b10, addr1=0x100, s_req_ack=1 -> s_req=1, s_addr=0x100, req_ack and m_req_ack[1] pulse 1 cycle.
REQ-031 Read accepted for id 0, s_resp=RDY with s_rdata=0xDEADBEEF 3 cycles later -> next cycle m_resp[0]=RDY, m_rdata[0]=0xDEADBEEF, lack=1 for 1 cycle, m_resp[1]=IDLE.
REQ-032 Accept id 1, gnt switches to 0 in WAIT_RESP, s_resp=ERR -> ERR routed to m_resp[1] only.
REQ-033 gnt=0, m_req[0] asserted 2 cycles then dropped while s_req_ack=0 -> no req_ack, state stays IDLE, later gnt=1 request accepted normally.
REQ-034 rst=1 in WAIT_RESP followed by s_resp=RDY -> no lack, all m_resp IDLE, next request accepted.
REQ-035 YCR_ROUTE_TIMEOUT_EN, TMO_CYC=8, no s_resp -> m_resp[id]=ERR, lack 8 cycles after acceptance; a later s_resp=RDY is ignored.
